// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32I/RV64I decode stage.
// Contents: opcode constants, format/op-class/state enums, the decoded_t
// payload struct (PC and immediate held at the widest supported XLEN), and a
// sign-extension helper.
// Optional feature macro used by the decoder: DECODE_RV32M_EN.
package decode_pkg;

  localparam int unsigned XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [3:0] {
    OP_ALU    = 4'd0,
    OP_ALUI   = 4'd1,
    OP_LOAD   = 4'd2,
    OP_STORE  = 4'd3,
    OP_BRANCH = 4'd4,
    OP_JAL    = 4'd5,
    OP_JALR   = 4'd6,
    OP_LUI    = 4'd7,
    OP_AUIPC  = 4'd8,
    OP_SYSTEM = 4'd9,
    OP_FENCE  = 4'd10,
    OP_MUL    = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    fmt_e                fmt;
    op_e                 op;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic                alt;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
  } decoded_t;

  // Sign-extend a 32-bit immediate to the widest XLEN; narrower XLENs truncate.
  function automatic logic [XLEN_MAX-1:0] sext32(input logic [31:0] v);
    return {{(XLEN_MAX-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I/RV64I decoder, (inst, pc) -> decoded_t.
// Ports:
//   i_inst  32    raw instruction word
//   i_pc    XLEN  instruction address
//   o_dec   decoded_t  decoded payload (registers unused by the format are 0)
// Macro DECODE_RV32M_EN: when defined, OP with funct7=0000001 decodes as MUL.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output decoded_t        o_dec
);

  localparam bit IS_RV32 = (XLEN == 32);

  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_shift;

  assign w_opc   = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_f7    = i_inst[31:25];
  assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

  // Opcode classification and legality
  always_comb begin
    o_dec         = '0;
    o_dec.pc      = XLEN_MAX'(i_pc);
    o_dec.funct3  = w_f3;
    o_dec.alt     = i_inst[30];
    o_dec.fmt     = FMT_R;
    o_dec.op      = OP_ALU;
    o_dec.illegal = 1'b0;

    case (w_opc)
      OPC_LOAD: begin
        o_dec.fmt     = FMT_I;
        o_dec.op      = OP_LOAD;
        o_dec.illegal = IS_RV32 ? (w_f3 == 3'b011 || w_f3 == 3'b110 || w_f3 == 3'b111)
                                : (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        o_dec.fmt     = FMT_S;
        o_dec.op      = OP_STORE;
        o_dec.illegal = IS_RV32 ? (w_f3 > 3'b010) : (w_f3 > 3'b011);
      end
      OPC_BRANCH: begin
        o_dec.fmt     = FMT_B;
        o_dec.op      = OP_BRANCH;
        o_dec.illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_JAL: begin
        o_dec.fmt = FMT_J;
        o_dec.op  = OP_JAL;
      end
      OPC_JALR: begin
        o_dec.fmt     = FMT_I;
        o_dec.op      = OP_JALR;
        o_dec.illegal = (w_f3 != 3'b000);
      end
      OPC_LUI: begin
        o_dec.fmt = FMT_U;
        o_dec.op  = OP_LUI;
      end
      OPC_AUIPC: begin
        o_dec.fmt = FMT_U;
        o_dec.op  = OP_AUIPC;
      end
      OPC_SYSTEM: begin
        o_dec.fmt = FMT_I;
        o_dec.op  = OP_SYSTEM;
      end
      OPC_MISC_MEM: begin
        o_dec.fmt = FMT_I;
        o_dec.op  = OP_FENCE;
      end
      OPC_OP_IMM: begin
        o_dec.fmt = FMT_I;
        o_dec.op  = OP_ALUI;
        // RV64 shamt is 6 bits wide, so only imm[11:6] is the shift-type field
        if (w_shift) begin
          if (IS_RV32) begin
            o_dec.illegal = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
          end else begin
            o_dec.illegal = !(i_inst[31:26] == 6'b000000 || i_inst[31:26] == 6'b010000);
          end
        end
      end
      OPC_OP: begin
        o_dec.fmt = FMT_R;
        o_dec.op  = OP_ALU;
        case (w_f7)
          7'b0000000: o_dec.illegal = 1'b0;
          7'b0100000: o_dec.illegal = !(w_f3 == 3'b000 || w_f3 == 3'b101);
`ifdef DECODE_RV32M_EN
          7'b0000001: o_dec.op = OP_MUL;
`else
          7'b0000001: o_dec.illegal = 1'b1;
`endif
          default:    o_dec.illegal = 1'b1;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase

    if (i_inst[1:0] != 2'b11 || i_inst == 32'h0000_0000) begin
      o_dec.illegal = 1'b1;
    end

    // Immediate and register fields per format
    case (o_dec.fmt)
      FMT_R: begin
        o_dec.rd  = i_inst[11:7];
        o_dec.rs1 = i_inst[19:15];
        o_dec.rs2 = i_inst[24:20];
      end
      FMT_I: begin
        o_dec.rd  = i_inst[11:7];
        o_dec.rs1 = i_inst[19:15];
        o_dec.imm = sext32({{20{i_inst[31]}}, i_inst[31:20]});
      end
      FMT_S: begin
        o_dec.rs1 = i_inst[19:15];
        o_dec.rs2 = i_inst[24:20];
        o_dec.imm = sext32({{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]});
      end
      FMT_B: begin
        o_dec.rs1 = i_inst[19:15];
        o_dec.rs2 = i_inst[24:20];
        o_dec.imm = sext32({{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                            i_inst[11:8], 1'b0});
      end
      FMT_U: begin
        o_dec.rd  = i_inst[11:7];
        o_dec.imm = sext32({i_inst[31:12], 12'b0});
      end
      FMT_J: begin
        o_dec.rd  = i_inst[11:7];
        o_dec.imm = sext32({{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                            i_inst[30:21], 1'b0});
      end
      default: o_dec.imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready handshaked RV32I/RV64I decode stage
// with a 2-slot (OUT + SKID) buffer, flush, and illegal-instruction flagging.
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_valid/o_ready         upstream handshake; i_inst, i_pc upstream payload
//   i_flush                 discard held and incoming entries
//   o_valid/i_ready         downstream handshake
//   o_pc, o_fmt, o_op, o_rd, o_rs1, o_rs2, o_funct3, o_alt, o_imm,
//   o_illegal, o_first      decoded payload (all register outputs)
// Macro DECODE_RV32M_EN (in decode_comb) enables MUL-class decode.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned RESET_PC_VALID = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [2:0]      o_fmt,
  output logic [3:0]      o_op,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic            o_alt,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal,
  output logic            o_first
);

  decoded_t w_dec;
  logic     w_acc;
  logic     w_deq;

  state_e   r_state;
  logic     r_valid;
  logic     r_ready;
  decoded_t r_out;
  decoded_t r_skid;
  logic     r_out_first;
  logic     r_skid_first;
  logic     r_first_pend;

  decode_comb #(.XLEN(XLEN)) u_decode_comb (
    .i_inst (i_inst),
    .i_pc   (i_pc),
    .o_dec  (w_dec)
  );

  assign w_acc = i_valid & r_ready;
  assign w_deq = r_valid & i_ready;

  // Slot state machine; r_ready tracks (next state != FULL)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_EMPTY;
      r_valid      <= 1'b0;
      r_ready      <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
      r_out_first  <= 1'b0;
      r_skid_first <= 1'b0;
      r_first_pend <= (RESET_PC_VALID != 0);
    end else if (i_flush) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_ready <= 1'b1;
      if (w_acc) begin
        r_first_pend <= 1'b0;
      end
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out       <= w_dec;
            r_out_first <= r_first_pend;
            r_valid     <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && !w_deq) begin
            r_skid       <= w_dec;
            r_skid_first <= r_first_pend;
            r_state      <= ST_FULL;
            r_ready      <= 1'b0;
          end else if (w_acc) begin
            r_out       <= w_dec;
            r_out_first <= r_first_pend;
          end else if (w_deq) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_deq) begin
            r_out       <= r_skid;
            r_out_first <= r_skid_first;
            r_state     <= ST_ONE;
          end else begin
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = r_valid;
  assign o_pc      = r_out.pc[XLEN-1:0];
  assign o_fmt     = r_out.fmt;
  assign o_op      = r_out.op;
  assign o_rd      = r_out.rd;
  assign o_rs1     = r_out.rs1;
  assign o_rs2     = r_out.rs2;
  assign o_funct3  = r_out.funct3;
  assign o_alt     = r_out.alt;
  assign o_imm     = r_out.imm[XLEN-1:0];
  assign o_illegal = r_out.illegal;
  assign o_first   = r_out_first;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage (XLEN=32,
// RESET_PC_VALID=1). Expected values are hand-computed from the ISA encodings.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] pc;
  logic            flush;
  logic            out_valid;
  logic            ds_ready;
  logic [XLEN-1:0] o_pc;
  logic [2:0]      o_fmt;
  logic [3:0]      o_op;
  logic [4:0]      o_rd;
  logic [4:0]      o_rs1;
  logic [4:0]      o_rs2;
  logic [2:0]      o_funct3;
  logic            o_alt;
  logic [XLEN-1:0] o_imm;
  logic            o_illegal;
  logic            o_first;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(XLEN), .RESET_PC_VALID(1)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (in_valid),
    .o_ready   (out_ready),
    .i_inst    (inst),
    .i_pc      (pc),
    .i_flush   (flush),
    .o_valid   (out_valid),
    .i_ready   (ds_ready),
    .o_pc      (o_pc),
    .o_fmt     (o_fmt),
    .o_op      (o_op),
    .o_rd      (o_rd),
    .o_rs1     (o_rs1),
    .o_rs2     (o_rs2),
    .o_funct3  (o_funct3),
    .o_alt     (o_alt),
    .o_imm     (o_imm),
    .o_illegal (o_illegal),
    .o_first   (o_first)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    in_valid = v;
    inst     = ins;
    pc       = p;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ds_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(out_ready), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_imm", 64'(o_imm), 64'd0);

    rst_n = 1'b1;
    step();
    chk("rel_ready", 64'(out_ready), 64'd1);
    chk("rel_valid", 64'(out_valid), 64'd0);

    // LB x0,0(x0)
    drive(1'b1, 32'h0000_0003, 32'h100);
    step();
    chk("lb_valid", 64'(out_valid), 64'd1);
    chk("lb_op", 64'(o_op), 64'(OP_LOAD));
    chk("lb_fmt", 64'(o_fmt), 64'(FMT_I));
    chk("lb_imm", 64'(o_imm), 64'd0);
    chk("lb_illegal", 64'(o_illegal), 64'd0);
    chk("lb_pc", 64'(o_pc), 64'h100);
    chk("lb_first", 64'(o_first), 64'd1);

    // All-zero word
    drive(1'b1, 32'h0000_0000, 32'h104);
    step();
    chk("zero_illegal", 64'(o_illegal), 64'd1);
    chk("zero_first", 64'(o_first), 64'd0);
    chk("zero_pc", 64'(o_pc), 64'h104);

    // ADDI x1,x0,-1
    drive(1'b1, 32'hFFF0_0093, 32'h108);
    step();
    chk("addi_imm", 64'(o_imm), 64'hFFFF_FFFF);
    chk("addi_rd", 64'(o_rd), 64'd1);
    chk("addi_op", 64'(o_op), 64'(OP_ALUI));
    chk("addi_rs2", 64'(o_rs2), 64'd0);
    chk("addi_illegal", 64'(o_illegal), 64'd0);

    // SUB x0,x1,x2
    drive(1'b1, 32'h4020_8033, 32'h10C);
    step();
    chk("sub_alt", 64'(o_alt), 64'd1);
    chk("sub_rs1", 64'(o_rs1), 64'd1);
    chk("sub_rs2", 64'(o_rs2), 64'd2);
    chk("sub_fmt", 64'(o_fmt), 64'(FMT_R));
    chk("sub_illegal", 64'(o_illegal), 64'd0);

    // OP with funct7=1000000 is illegal
    drive(1'b1, 32'h8020_8033, 32'h110);
    step();
    chk("f7bad_illegal", 64'(o_illegal), 64'd1);

    // BEQ-class opcode with funct3=010 is illegal
    drive(1'b1, 32'h0000_2063, 32'h114);
    step();
    chk("br010_illegal", 64'(o_illegal), 64'd1);
    chk("br010_fmt", 64'(o_fmt), 64'(FMT_B));

    // JAL x1,+8
    drive(1'b1, 32'h0080_00EF, 32'h118);
    step();
    chk("jal_op", 64'(o_op), 64'(OP_JAL));
    chk("jal_fmt", 64'(o_fmt), 64'(FMT_J));
    chk("jal_imm", 64'(o_imm), 64'd8);
    chk("jal_rd", 64'(o_rd), 64'd1);
    chk("jal_rs1", 64'(o_rs1), 64'd0);

    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: 4 back-to-back with i_ready low
    ds_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h200);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_ready", 64'(out_ready), 64'd1);
    drive(1'b1, 32'h0000_0013, 32'h204);
    step();
    chk("bp_full_ready", 64'(out_ready), 64'd0);
    chk("bp_full_pc", 64'(o_pc), 64'h200);
    drive(1'b1, 32'h0000_0013, 32'h208);
    step();
    chk("bp_hold_pc", 64'(o_pc), 64'h200);
    chk("bp_hold_ready", 64'(out_ready), 64'd0);
    ds_ready = 1'b1;
    step();
    chk("bp_b_pc", 64'(o_pc), 64'h204);
    chk("bp_b_ready", 64'(out_ready), 64'd1);
    step();
    chk("bp_c_pc", 64'(o_pc), 64'h208);
    drive(1'b1, 32'h0000_0013, 32'h20C);
    step();
    chk("bp_d_pc", 64'(o_pc), 64'h20C);
    chk("bp_d_valid", 64'(out_valid), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_end_valid", 64'(out_valid), 64'd0);

    // Flush while FULL with a valid input
    ds_ready = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h300);
    step();
    drive(1'b1, 32'h0000_0013, 32'h304);
    step();
    chk("fl_full_ready", 64'(out_ready), 64'd0);
    flush = 1'b1;
    drive(1'b1, 32'h0000_0013, 32'h308);
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(out_ready), 64'd1);
    flush = 1'b0;
    drive(1'b1, 32'h0000_0013, 32'h30C);
    step();
    chk("fl_next_valid", 64'(out_valid), 64'd1);
    chk("fl_next_pc", 64'(o_pc), 64'h30C);
    ds_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("fl_drain_valid", 64'(out_valid), 64'd0);

    // MUL x0,x1,x2
    drive(1'b1, 32'h0220_8033, 32'h400);
    step();
    chk("mul_fmt", 64'(o_fmt), 64'(FMT_R));
`ifdef DECODE_RV32M_EN
    chk("mul_op", 64'(o_op), 64'(OP_MUL));
    chk("mul_illegal", 64'(o_illegal), 64'd0);
`else
    chk("mul_op", 64'(o_op), 64'(OP_ALU));
    chk("mul_illegal", 64'(o_illegal), 64'd1);
`endif
    drive(1'b0, 32'h0, 32'h0);
    step();

    // Reset while FULL
    ds_ready = 1'b0;
    drive(1'b1, 32'hFFF0_0093, 32'h500);
    step();
    drive(1'b1, 32'hFFF0_0093, 32'h504);
    step();
    chk("rf_full_ready", 64'(out_ready), 64'd0);
    chk("rf_full_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("rf_valid", 64'(out_valid), 64'd0);
    chk("rf_ready", 64'(out_ready), 64'd0);
    chk("rf_pc", 64'(o_pc), 64'd0);
    chk("rf_imm", 64'(o_imm), 64'd0);
    chk("rf_op", 64'(o_op), 64'd0);
    chk("rf_rd", 64'(o_rd), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rf_rel_ready", 64'(out_ready), 64'd1);
    chk("rf_rel_valid", 64'(out_valid), 64'd0);
    ds_ready = 1'b1;
    drive(1'b1, 32'hFFF0_0093, 32'h600);
    step();
    chk("rf_new_valid", 64'(out_valid), 64'd1);
    chk("rf_new_pc", 64'(o_pc), 64'h600);
    chk("rf_new_first", 64'(o_first), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
